hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, default 3, register-address width; the register file holds 2**REG_AW entries.
REQ-002 Parameter LOAD_LAT, default 1, range 1..4, load-use stall length in cycles.
REQ-003 Parameter ZERO_REG, default 0; when 1, register 0 is hardwired: never forwarded, never a hazard source.
REQ-004 Parameter CNT_W, default 16, stall-counter width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 RA1D, RA2D  in  REG_AW  Decode-stage source registers.
REQ-008 RA1E, RA2E, WA3E  in  REG_AW  Execute-stage sources and destination.
REQ-009 WA3M, WA3W  in  REG_AW  Memory-stage and Writeback-stage destinations.
REQ-010 RegWriteE, RegWriteM, RegWriteW  in  1  destination valid in E, M, W.
REQ-011 MemtoRegE  in  1  instruction in E is a load.
REQ-012 PCWriteD  in  1  instruction in D writes the PC.
REQ-013 BranchTakenE  in  1  branch resolved taken in E.
REQ-014 ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 W result, 10 M result.
REQ-015 StallF, StallD, FlushD, FlushE  out  1  pipeline control.
REQ-016 hz_state  out  2  FSM state, debug only.
REQ-017 stall_count  out  CNT_W  cycles with StallD asserted since reset.

Function
REQ-018 Forwarding SHALL be combinational: M match with RegWriteM gives 10; otherwise W match with RegWriteW gives 01; otherwise 00; M wins when both match.
REQ-019 With ZERO_REG=1, a source of 0 SHALL produce 00 and SHALL NOT trigger a load-use hazard.
REQ-020 FSM states SHALL be IDLE=00, LD_STALL=01, PC_DRAIN=10.
REQ-021 ld_hit SHALL be asserted when the FSM is in IDLE, MemtoRegE=1, RegWriteE=1 and (RA1D==WA3E or RA2D==WA3E).
REQ-022 On ld_hit, the FSM SHALL assert StallF, StallD and FlushE in the same cycle.
REQ-023 On ld_hit with LOAD_LAT>1, the FSM SHALL enter LD_STALL with counter=LOAD_LAT-2.
REQ-024 On ld_hit with LOAD_LAT=1, the FSM SHALL remain in IDLE.
REQ-025 In LD_STALL, StallF, StallD and FlushE SHALL stay asserted, and the counter SHALL decrement each cycle.
REQ-026 The FSM SHALL leave LD_STALL at counter 0, so total stall = LOAD_LAT cycles.
REQ-027 The pcw[E,M,W] shift register SHALL advance every cycle: pcw_E <= PCWriteD && !FlushE; pcw_M <= pcw_E; pcw_W <= pcw_M.
REQ-028 PCWrPending SHALL equal PCWriteD | pcw_E | pcw_M.
REQ-029 The FSM SHALL be in PC_DRAIN whenever any pcw bit is set and it is not in LD_STALL, and SHALL return to IDLE when the bits clear.
REQ-030 StallF SHALL equal load stall | PCWrPending.
REQ-031 StallD SHALL equal load stall.
REQ-032 FlushE SHALL equal load stall | BranchTakenE.
REQ-033 FlushD SHALL equal PCWrPending | pcw_W | BranchTakenE.
REQ-034 BranchTakenE during a PC drain SHALL add its flushes without clearing pcw.
REQ-035 stall_count SHALL increment on each cycle with StallD=1 and SHALL saturate at 2**CNT_W-1.

Reset
REQ-036 While rst=1, the block SHALL drive FSM=IDLE, the counter to 0, pcw to 000 and stall_count to 0.
REQ-037 While rst=1, the block SHALL drive StallF=0, StallD=0, FlushD=1, FlushE=1 and ForwardAE=ForwardBE=00.
REQ-038 Reset asserted mid-stall or mid-drain SHALL abort the stall or drain; the first cycle after release SHALL behave as a fresh IDLE.

Structure
REQ-039 A shared package hazard_pkg SHALL hold the FSM state enum and the forward-select constants FWD_RF, FWD_W and FWD_M.
REQ-040 Forwarding compare SHALL be one sub-module, fwd_sel, instantiated twice (operands A and B).

Verification
REQ-041 M/W priority test: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10; with RegWriteM=0 -> 01.
REQ-042 Zero-register test: ZERO_REG=1, RA2E=0, WA3M=0, RegWriteM=1 -> ForwardBE=00; with ZERO_REG=0 -> 10.
REQ-043 Long load-use test: LOAD_LAT=3, MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 -> StallD=1 for exactly 3 cycles; FlushE=1 for those cycles; stall_count=3.
REQ-044 PC-write test: PCWriteD=1 for one cycle -> StallF=1 for 3 cycles; FlushD=1 for 4 cycles; hz_state=10 for 3 cycles, then 00.
REQ-045 Mid-stall reset test: rst=1 in the 2nd LD_STALL cycle with LOAD_LAT=4 -> next cycle StallD=0, hz_state=00, stall_count=0.
REQ-046 Saturation test: CNT_W=4 with 20 stall cycles -> stall_count holds at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
//   hzState_e  : hazard FSM state encoding (also exported on hz_state)
//   FWD_*      : operand-select codes driven on ForwardAE / ForwardBE
package hazard_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StLdStall = 2'b01,
    StPcDrain = 2'b10
  } hzState_e;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from Writeback result
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from Memory result

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one Execute-stage source operand.
//   srcE                 : Execute-stage source register address
//   wa3M, wa3W           : Memory / Writeback destination addresses
//   regWriteM, regWriteW : destination valid in M / W
//   fwdSel               : FWD_M, FWD_W or FWD_RF (M has priority over W)
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic [REG_AW-1:0] srcE,
  input  logic [REG_AW-1:0] wa3M,
  input  logic [REG_AW-1:0] wa3W,
  input  logic              regWriteM,
  input  logic              regWriteW,
  output logic [1:0]        fwdSel
);

  logic srcLive;

  // A hardwired zero register always reads from the register file.
  assign srcLive = !((ZERO_REG != 0) && (srcE == '0));

  always_comb begin
    fwdSel = FWD_RF;
    if (srcLive && regWriteM && (srcE == wa3M)) begin
      fwdSel = FWD_M;
    end else if (srcLive && regWriteW && (srcE == wa3W)) begin
      fwdSel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, load-use stalls and PC-write drains.
//   clk, rst                  : clock, synchronous active-high reset
//   RA1D, RA2D                : Decode-stage source registers
//   RA1E, RA2E, WA3E          : Execute-stage sources and destination
//   WA3M, WA3W                : Memory / Writeback destinations
//   RegWriteE/M/W             : destination valid per stage
//   MemtoRegE                 : Execute-stage instruction is a load
//   PCWriteD                  : Decode-stage instruction writes the PC
//   BranchTakenE              : branch resolved taken in Execute
//   ForwardAE, ForwardBE      : operand select (00 RF, 01 W, 10 M)
//   StallF, StallD            : hold Fetch / Decode
//   FlushD, FlushE            : bubble Decode / Execute
//   hz_state                  : FSM state (debug)
//   stall_count               : saturating count of StallD cycles since reset
// LOAD_LAT is expected in 1..4.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              PCWriteD,
  input  logic              BranchTakenE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        hz_state,
  output logic [CNT_W-1:0]  stall_count
);

  // Remaining LD_STALL cycles after the ld_hit cycle, minus one.
  localparam logic [1:0] LatInit = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

  hzState_e         stateQ, stateD;
  logic [1:0]       latCntQ, latCntD;
  logic [2:0]       pcwQ, pcwD;  // [0]=E, [1]=M, [2]=W
  logic [CNT_W-1:0] stallCntQ, stallCntD;

  logic [1:0] fwdA, fwdB;
  logic       ra1Live, ra2Live;
  logic       ldHit, loadStall, pcWrPending, flushECore;

  fwd_sel #(
    .REG_AW  (REG_AW),
    .ZERO_REG(ZERO_REG)
  ) u_fwd_a (
    .srcE     (RA1E),
    .wa3M     (WA3M),
    .wa3W     (WA3W),
    .regWriteM(RegWriteM),
    .regWriteW(RegWriteW),
    .fwdSel   (fwdA)
  );

  fwd_sel #(
    .REG_AW  (REG_AW),
    .ZERO_REG(ZERO_REG)
  ) u_fwd_b (
    .srcE     (RA2E),
    .wa3M     (WA3M),
    .wa3W     (WA3W),
    .regWriteM(RegWriteM),
    .regWriteW(RegWriteW),
    .fwdSel   (fwdB)
  );

  // A hardwired zero register never creates a load-use dependency.
  assign ra1Live = !((ZERO_REG != 0) && (RA1D == '0));
  assign ra2Live = !((ZERO_REG != 0) && (RA2D == '0));

  assign ldHit = (stateQ == StIdle) && MemtoRegE && RegWriteE &&
                 ((ra1Live && (RA1D == WA3E)) || (ra2Live && (RA2D == WA3E)));

  assign loadStall   = ldHit || (stateQ == StLdStall);
  assign pcWrPending = PCWriteD | pcwQ[0] | pcwQ[1];
  assign flushECore  = loadStall | BranchTakenE;

  // Reset forces a safe pipeline: nothing stalled, D and E flushed, no forwarding.
  assign ForwardAE   = rst ? FWD_RF : fwdA;
  assign ForwardBE   = rst ? FWD_RF : fwdB;
  assign StallF      = !rst && (loadStall || pcWrPending);
  assign StallD      = !rst && loadStall;
  assign FlushE      = rst || flushECore;
  assign FlushD      = rst || pcWrPending || pcwQ[2] || BranchTakenE;
  assign hz_state    = stateQ;
  assign stall_count = stallCntQ;

  always_comb begin
    stateD  = stateQ;
    latCntD = latCntQ;
    // A PC-writing instruction squashed out of E never starts a drain.
    pcwD    = {pcwQ[1], pcwQ[0], PCWriteD && !flushECore};

    unique case (stateQ)
      StIdle, StPcDrain: begin
        if (ldHit && (LOAD_LAT > 1)) begin
          stateD  = StLdStall;
          latCntD = LatInit;
        end else begin
          stateD = (pcwD != 3'b000) ? StPcDrain : StIdle;
        end
      end
      StLdStall: begin
        if (latCntQ == 2'd0) begin
          stateD = (pcwD != 3'b000) ? StPcDrain : StIdle;
        end else begin
          latCntD = latCntQ - 2'd1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    stallCntD = stallCntQ;
    if (loadStall && (stallCntQ != '1)) begin
      stallCntD = stallCntQ + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= StIdle;
      latCntQ   <= 2'd0;
      pcwQ      <= 3'b000;
      stallCntQ <= '0;
    end else begin
      stateQ    <= stateD;
      latCntQ   <= latCntD;
      pcwQ      <= pcwD;
      stallCntQ <= stallCntD;
    end
  end

endmodule
